key_multi_funcmod: RTL and testbench
====================================

KEY_MULTI_FUNCMOD -- requirements
Module: key_multi_funcmod

Interface
REQ-001 Parameter N, default 4: number of independent key channels, 1..16.
REQ-002 Parameter CW, default 28: width of every per-channel timer; must hold the largest T_* value.
REQ-003 Parameter T_DEB, default 500_000: debounce hold, in cycles (10 ms at 50 MHz).
REQ-004 Parameter T_GAP, default 5_000_000: double-click window after release debounce, in cycles.
REQ-005 Parameter T_LONG, default 150_000_000: long-press threshold after press debounce, in cycles.
REQ-006 Parameter T_REP, default 10_000_000: auto-repeat period, in cycles (used only with REQ-030).
REQ-007 CLOCK  in  1  system clock; all logic on its rising edge.
REQ-008 RESET  in  1  asynchronous, active-low reset.
REQ-009 KEY  in  N  raw key levels, asynchronous to CLOCK; idle high, pressed low.
REQ-010 oSClick  out  N  single-click pulse, one per channel.
REQ-011 oDClick  out  N  double-click pulse, one per channel.
REQ-012 oLClick  out  N  long-press pulse, one per channel.
REQ-013 oRepeat  out  N  auto-repeat pulse, one per channel.

Function
REQ-014 Each channel has its own 2-flop synchroniser (F1, F2), FSM and timer; channels share nothing.
- Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.
REQ-015 Edge detection: fall = (F2==1 && F1==0); rise = (F2==0 && F1==1).
REQ-016 FSM states: IDLE, DEB_DN, HELD, DEB_UP, GAP, DEB_DN2, WAIT_REL, DEB_REL.
REQ-017 IDLE: on fall -> DEB_DN with timer=0.
REQ-018 DEB_DN, DEB_UP, DEB_DN2, DEB_REL: timer counts; input is ignored.
- When timer==T_DEB-1, clear timer and go to HELD, GAP, WAIT_REL and IDLE respectively.
REQ-019 HELD: on rise -> DEB_UP, timer=0.
- Else when timer==T_LONG-1 -> pulse oLClick, go to WAIT_REL, timer=0.
- Rise in the same cycle as the terminal count: rise wins, no long press.
REQ-020 GAP: on fall -> pulse oDClick, go to DEB_DN2, timer=0.
- Else when timer==T_GAP-1 -> pulse oSClick, go to IDLE.
- Fall in the same cycle as the terminal count: double click wins.
REQ-021 WAIT_REL: on rise -> DEB_REL, timer=0.
REQ-022 Output pulses are registered, high for exactly one cycle, and rise in the cycle after the deciding state's evaluation.
- At most one of oSClick/oDClick/oLClick is high per channel in any cycle.
REQ-023 A third press within the window after a double click is not classified; it is absorbed until WAIT_REL/DEB_REL returns the channel to IDLE.
REQ-024 Timers saturate, never wrap, if a parameter exceeds 2^CW-1.

Reset
REQ-025 On RESET low, asynchronously:
- F1 and F2 of every channel set to 1;
- every FSM set to IDLE and every timer set to 0;
- oSClick, oDClick, oLClick and oRepeat set to all zeros.
REQ-026 A reset asserted mid-gesture discards that gesture; no pulse is emitted for it after release of reset.
REQ-027 After reset release, a key already held low produces no event until it has been seen high and then falls again.

Configuration
REQ-028 Macro KEY_AUTO_REPEAT_EN selects the auto-repeat feature.
REQ-029 Without KEY_AUTO_REPEAT_EN: oRepeat is constant 0 and no repeat timer is built.
REQ-030 With KEY_AUTO_REPEAT_EN: in WAIT_REL, entered via long press, while the key is still low, oRepeat pulses for one cycle every T_REP cycles.
- First oRepeat pulse comes T_REP cycles after the oLClick pulse.
- Repeat stops on the cycle rise is detected.
- WAIT_REL entered via DEB_DN2 produces no repeats.

Verification (N=2, T_DEB=4, T_GAP=20, T_LONG=100, T_REP=10)
REQ-031 KEY[0] low for 30 cycles, then high -> exactly one oSClick[0] pulse, 20-30 cycles after release; no other outputs fire.
REQ-032 KEY[0] low 15, high 10, low 15, high -> exactly one oDClick[0] pulse, during the second press; no oSClick.
REQ-033 KEY[1] low 150 cycles -> one oLClick[1] pulse about 106 cycles after the fall.
- With the macro: oRepeat[1] pulses 10, 20, 30, 40 cycles after oLClick; none after release.
- Without the macro: oRepeat stays 0.
REQ-034 KEY[0] bounce (3 toggles within 3 cycles) on press and release, nominal press 30 cycles -> single oSClick[0] only.
REQ-035 Both keys pressed together, KEY[0] single click and KEY[1] long press -> oSClick[0] and oLClick[1] each fire once, independently.
REQ-036 RESET pulsed low during HELD on channel 0 -> all outputs 0 immediately; no pulse after release until a new full press.

Source files
------------

// File: rtl/key_multi_funcmod.sv
`default_nettype none
// ============================================================================
//  Module      : key_multi_funcmod
//  Description : N-channel key classifier. Each channel synchronises its raw
//                key level, debounces press and release, and classifies the
//                gesture as single click, double click or long press, each
//                reported as a one-cycle pulse.
//                Optional feature macro: KEY_AUTO_REPEAT_EN. When defined, a
//                long press that is still held emits oRepeat every T_REP
//                cycles. When undefined, oRepeat is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_multi_funcmod #(
    parameter int N      = 4,
    parameter int CW     = 28,
    parameter int T_DEB  = 500_000,
    parameter int T_GAP  = 5_000_000,
    parameter int T_LONG = 150_000_000,
    parameter int T_REP  = 10_000_000
) (
    input  logic         CLOCK,
    input  logic         RESET,
    input  logic [N-1:0] KEY,
    output logic [N-1:0] oSClick,
    output logic [N-1:0] oDClick,
    output logic [N-1:0] oLClick,
    output logic [N-1:0] oRepeat
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEB_DN   = 3'd1,
        HELD     = 3'd2,
        DEB_UP   = 3'd3,
        GAP      = 3'd4,
        DEB_DN2  = 3'd5,
        WAIT_REL = 3'd6,
        DEB_REL  = 3'd7
    } state_t;

    // Terminal counts compared at 64 bits, so an oversized parameter can never
    // alias onto a truncated value; the saturated timer then simply never hits.
    localparam logic [63:0] DEB_LAST  = 64'(T_DEB)  - 64'd1;
    localparam logic [63:0] GAP_LAST  = 64'(T_GAP)  - 64'd1;
    localparam logic [63:0] LONG_LAST = 64'(T_LONG) - 64'd1;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic          f1;
        logic          f2;
        logic [1:0]    fill;
        logic          fall;
        logic          rise;
        state_t        state;
        state_t        state_nx;
        logic [CW-1:0] timer;
        logic [CW-1:0] timer_nx;
        logic [CW-1:0] timer_inc;
        logic [63:0]   t_ext;
        logic          s_nx;
        logic          d_nx;
        logic          l_nx;
        logic          s_q;
        logic          d_q;
        logic          l_q;

        // Edges are only trusted once both synchroniser flops hold real
        // samples; this keeps a key held low across reset from looking like
        // a fresh press.
        assign fall      = fill[1] &  f2 & ~f1;
        assign rise      = fill[1] & ~f2 &  f1;
        assign timer_inc = (&timer) ? timer : timer + 1'b1;
        assign t_ext     = 64'(timer);

        // Two-flop synchroniser plus fill tracker for the raw key level
        always_ff @(posedge CLOCK or negedge RESET) begin
            if (!RESET) begin
                f1   <= 1'b1;
                f2   <= 1'b1;
                fill <= 2'b00;
            end else begin
                f1   <= KEY[i];
                f2   <= f1;
                fill <= {fill[0], 1'b1};
            end
        end

        // State, timer and registered event pulses
        always_ff @(posedge CLOCK or negedge RESET) begin
            if (!RESET) begin
                state <= IDLE;
                timer <= '0;
                s_q   <= 1'b0;
                d_q   <= 1'b0;
                l_q   <= 1'b0;
            end else begin
                state <= state_nx;
                timer <= timer_nx;
                s_q   <= s_nx;
                d_q   <= d_nx;
                l_q   <= l_nx;
            end
        end

        // Gesture classification: next state, timer and pulse requests
        always_comb begin
            state_nx = state;
            timer_nx = timer_inc;
            s_nx     = 1'b0;
            d_nx     = 1'b0;
            l_nx     = 1'b0;
            case (state)
                IDLE: begin
                    timer_nx = '0;
                    if (fall) state_nx = DEB_DN;
                end
                DEB_DN: begin
                    if (t_ext == DEB_LAST) begin
                        state_nx = HELD;
                        timer_nx = '0;
                    end
                end
                HELD: begin
                    // Release beats a coincident long-press terminal count
                    if (rise) begin
                        state_nx = DEB_UP;
                        timer_nx = '0;
                    end else if (t_ext == LONG_LAST) begin
                        l_nx     = 1'b1;
                        state_nx = WAIT_REL;
                        timer_nx = '0;
                    end
                end
                DEB_UP: begin
                    if (t_ext == DEB_LAST) begin
                        state_nx = GAP;
                        timer_nx = '0;
                    end
                end
                GAP: begin
                    // A second press beats a coincident window expiry
                    if (fall) begin
                        d_nx     = 1'b1;
                        state_nx = DEB_DN2;
                        timer_nx = '0;
                    end else if (t_ext == GAP_LAST) begin
                        s_nx     = 1'b1;
                        state_nx = IDLE;
                        timer_nx = '0;
                    end
                end
                DEB_DN2: begin
                    if (t_ext == DEB_LAST) begin
                        state_nx = WAIT_REL;
                        timer_nx = '0;
                    end
                end
                WAIT_REL: begin
                    timer_nx = '0;
                    if (rise) state_nx = DEB_REL;
                end
                DEB_REL: begin
                    if (t_ext == DEB_LAST) begin
                        state_nx = IDLE;
                        timer_nx = '0;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    timer_nx = '0;
                end
            endcase
        end

        assign oSClick[i] = s_q;
        assign oDClick[i] = d_q;
        assign oLClick[i] = l_q;

`ifdef KEY_AUTO_REPEAT_EN
        localparam logic [63:0] REP_LAST = 64'(T_REP) - 64'd1;

        logic          rep_on;
        logic [CW-1:0] rep_timer;
        logic          rep_q;

        // Auto-repeat: armed only by a long press, cleared on release or on
        // leaving WAIT_REL, so WAIT_REL reached after a double click is silent
        always_ff @(posedge CLOCK or negedge RESET) begin
            if (!RESET) begin
                rep_on    <= 1'b0;
                rep_timer <= '0;
                rep_q     <= 1'b0;
            end else begin
                rep_q <= 1'b0;
                if (l_nx) begin
                    rep_on    <= 1'b1;
                    rep_timer <= '0;
                end else if (state != WAIT_REL || rise) begin
                    rep_on    <= 1'b0;
                    rep_timer <= '0;
                end else if (rep_on) begin
                    if (64'(rep_timer) == REP_LAST) begin
                        rep_q     <= 1'b1;
                        rep_timer <= '0;
                    end else if (!(&rep_timer)) begin
                        rep_timer <= rep_timer + 1'b1;
                    end
                end
            end
        end

        assign oRepeat[i] = rep_q;
`else
        assign oRepeat[i] = 1'b0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_key_multi_funcmod.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_multi_funcmod
//  Description : Self-checking bench for key_multi_funcmod. A deadline-based
//                gesture model predicts every output each cycle; directed
//                gestures and randomized key waveforms drive both.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_multi_funcmod;

    localparam int N      = 2;
    localparam int CW     = 8;
    localparam int T_DEB  = 4;
    localparam int T_GAP  = 20;
    localparam int T_LONG = 100;
    localparam int T_REP  = 10;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] key   = '1;
    logic [N-1:0] sc;
    logic [N-1:0] dc;
    logic [N-1:0] lc;
    logic [N-1:0] rp;

    always #5 clk = ~clk;

    key_multi_funcmod #(
        .N(N), .CW(CW), .T_DEB(T_DEB), .T_GAP(T_GAP),
        .T_LONG(T_LONG), .T_REP(T_REP)
    ) dut (
        .CLOCK   (clk),
        .RESET   (rst_n),
        .KEY     (key),
        .oSClick (sc),
        .oDClick (dc),
        .oLClick (lc),
        .oRepeat (rp)
    );

    int errors = 0;
    int checks = 0;

    // Gesture model: phase per channel plus absolute-cycle deadlines
    int       ph    [N];
    longint   dl    [N];
    longint   rdl   [N];
    bit       rep_on[N];
    bit       mf1   [N];
    bit       mf2   [N];
    int       nsamp;
    longint   cyc;
    logic [N-1:0] es, ed, el, er;

    int cnt_s0, cnt_d0, cnt_l1, cnt_r1, cnt_all;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < N; ch++) begin
            ph[ch]     = 0;
            dl[ch]     = 0;
            rdl[ch]    = 0;
            rep_on[ch] = 1'b0;
            mf1[ch]    = 1'b1;
            mf2[ch]    = 1'b1;
        end
        nsamp = 0;
        es = '0; ed = '0; el = '0; er = '0;
    endtask

    // Phases: 0 idle, 1 press debounce, 2 held, 3 release debounce, 4 gap,
    // 5 second-press debounce, 6 wait release, 7 final release debounce.
    task automatic model_edge(input logic [N-1:0] v);
        cyc++;
        es = '0; ed = '0; el = '0; er = '0;
        for (int ch = 0; ch < N; ch++) begin
            bit fall;
            bit rise;
            fall = (nsamp >= 2) &&  mf2[ch] && !mf1[ch];
            rise = (nsamp >= 2) && !mf2[ch] &&  mf1[ch];
            case (ph[ch])
                0: if (fall) begin ph[ch] = 1; dl[ch] = cyc + T_DEB; end
                1: if (cyc == dl[ch]) begin ph[ch] = 2; dl[ch] = cyc + T_LONG; end
                2: begin
                    if (rise) begin
                        ph[ch] = 3; dl[ch] = cyc + T_DEB;
                    end else if (cyc == dl[ch]) begin
                        el[ch] = 1'b1; ph[ch] = 6;
                        rep_on[ch] = 1'b1; rdl[ch] = cyc + T_REP;
                    end
                end
                3: if (cyc == dl[ch]) begin ph[ch] = 4; dl[ch] = cyc + T_GAP; end
                4: begin
                    if (fall) begin
                        ed[ch] = 1'b1; ph[ch] = 5; dl[ch] = cyc + T_DEB;
                    end else if (cyc == dl[ch]) begin
                        es[ch] = 1'b1; ph[ch] = 0;
                    end
                end
                5: if (cyc == dl[ch]) begin ph[ch] = 6; rep_on[ch] = 1'b0; end
                6: begin
                    if (rise) begin
                        ph[ch] = 7; dl[ch] = cyc + T_DEB; rep_on[ch] = 1'b0;
                    end else if (rep_on[ch] && cyc == rdl[ch]) begin
`ifdef KEY_AUTO_REPEAT_EN
                        er[ch] = 1'b1;
`endif
                        rdl[ch] = cyc + T_REP;
                    end
                end
                default: if (cyc == dl[ch]) ph[ch] = 0;
            endcase
            mf2[ch] = mf1[ch];
            mf1[ch] = v[ch];
        end
        if (nsamp < 2) nsamp++;
    endtask

    task automatic step(input logic [N-1:0] v);
        key = v;
        @(posedge clk);
        model_edge(v);
        @(negedge clk);
        check("sclick", 32'(sc), 32'(es));
        check("dclick", 32'(dc), 32'(ed));
        check("lclick", 32'(lc), 32'(el));
        check("repeat", 32'(rp), 32'(er));
        cnt_s0  += int'(sc[0]);
        cnt_d0  += int'(dc[0]);
        cnt_l1  += int'(lc[1]);
        cnt_r1  += int'(rp[1]);
        cnt_all += $countones({sc, dc, lc});
    endtask

    task automatic hold(input logic [N-1:0] v, input int n);
        repeat (n) step(v);
    endtask

    task automatic clear_counts();
        cnt_s0 = 0; cnt_d0 = 0; cnt_l1 = 0; cnt_r1 = 0; cnt_all = 0;
    endtask

    // Called just after a falling clock edge; releases on a falling edge
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        #1;
        check("rst_out", 32'({sc, dc, lc, rp}), 32'd0);
        model_reset();
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int rem[N];
        logic [N-1:0] lvl;
        int pick;
        int exp_rep;

        cyc = 0;
        clear_counts();
        @(negedge clk);
        do_reset(3);

        // Single click on channel 0
        clear_counts();
        hold(2'b11, 10); hold(2'b10, 30); hold(2'b11, 40);
        check("single_cnt", 32'(cnt_s0), 32'd1);
        check("single_only", 32'(cnt_all), 32'd1);

        // Double click on channel 0
        clear_counts();
        hold(2'b10, 15); hold(2'b11, 10); hold(2'b10, 15); hold(2'b11, 40);
        check("double_cnt", 32'(cnt_d0), 32'd1);
        check("double_only", 32'(cnt_all), 32'd1);

        // Long press on channel 1, with or without auto-repeat
        clear_counts();
        hold(2'b01, 150); hold(2'b11, 40);
        check("long_cnt", 32'(cnt_l1), 32'd1);
        check("long_only", 32'(cnt_all), 32'd1);
`ifdef KEY_AUTO_REPEAT_EN
        exp_rep = 4;
`else
        exp_rep = 0;
`endif
        check("repeat_cnt", 32'(cnt_r1), 32'(exp_rep));

        // Bouncy press and release on channel 0
        clear_counts();
        hold(2'b10, 1); hold(2'b11, 1); hold(2'b10, 30);
        hold(2'b11, 1); hold(2'b10, 1); hold(2'b11, 40);
        check("bounce_cnt", 32'(cnt_s0), 32'd1);
        check("bounce_only", 32'(cnt_all), 32'd1);

        // Both channels together: click on 0, long press on 1
        clear_counts();
        hold(2'b00, 30); hold(2'b01, 120); hold(2'b11, 40);
        check("both_s0", 32'(cnt_s0), 32'd1);
        check("both_l1", 32'(cnt_l1), 32'd1);
        check("both_total", 32'(cnt_all), 32'd2);

        // Reset in HELD discards the gesture; key still low is ignored
        clear_counts();
        hold(2'b10, 20);
        do_reset(3);
        hold(2'b10, 20); hold(2'b11, 60);
        check("rst_silent", 32'(cnt_all), 32'd0);
        hold(2'b10, 30); hold(2'b11, 40);
        check("rst_new_click", 32'(cnt_s0), 32'd1);

        // Randomized waveforms, each channel independent, one mid-run reset
        lvl = 2'b11;
        for (int ch = 0; ch < N; ch++) rem[ch] = $urandom_range(1, 40);
        for (int s = 0; s < 6000; s++) begin
            for (int ch = 0; ch < N; ch++) begin
                rem[ch]--;
                if (rem[ch] <= 0) begin
                    lvl[ch] = ~lvl[ch];
                    pick = $urandom_range(0, 9);
                    if (pick < 3)      rem[ch] = $urandom_range(1, 6);
                    else if (pick < 8) rem[ch] = $urandom_range(7, 40);
                    else               rem[ch] = $urandom_range(80, 160);
                end
            end
            step(lvl);
            if (s == 3000) do_reset(2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
